fp_reg_file_sb: RTL
===================

FP_REG_FILE_SB -- requirements
Module: fp_reg_file_sb

Interface
REQ-001 SHALL have parameter FLEN, default 32, register data width (32 or 64 only).
REQ-002 SHALL have parameter NRD, default 3, number of read ports (1..4).
REQ-003 SHALL have parameter F0_WRITABLE, default 1, 1 makes f0 an ordinary register, 0 makes f0 write-protected.
REQ-004 clock  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 rd_addr  in  NRD*5  read addresses, port i at bits [5i+4:5i].
REQ-007 rd_sgl  in  NRD  per-port single-precision read request.
REQ-008 rd_data  out  NRD*FLEN  read data, combinational.
REQ-009 wa_we / wa_addr / wa_data / wa_sgl  in  1/5/FLEN/1  short-latency writeback port.
REQ-010 wb_we / wb_addr / wb_data / wb_sgl  in  1/5/FLEN/1  long-latency writeback port (div/sqrt); also clears the scoreboard.
REQ-011 iss_valid / iss_rd / iss_rs / iss_lng  in  1/5/NRD*5/1  issue request: destination, sources, long-latency flag.
REQ-012 iss_stall  out  1  issue must be held, combinational.
REQ-013 busy  out  32  scoreboard pending-write bits.
REQ-014 fs_dirty / fs_clr  out/in  1/1  FP-state-dirty flag and its clear strobe.

Function
REQ-015 Read SHALL be write-first: if a port's address matches an enabled write this cycle, rd_data SHALL return that write's (boxed) data, wb priority over wa.
REQ-016 With both writes enabled to the same address, wb SHALL be stored and wa discarded.
REQ-017 Writes to address 0 SHALL be ignored when F0_WRITABLE=0, including bypass (reads of f0 return stored value).
REQ-018 FLEN=64 and *_sgl=1: stored value SHALL be {32'hFFFFFFFF, data[31:0]} (NaN-boxing).
REQ-019 FLEN=64 read with rd_sgl=1: if upper 32 bits are not all ones, low 32 bits of rd_data SHALL be 32'h7FC00000, upper all ones.
REQ-020 FLEN=32: *_sgl and rd_sgl SHALL be ignored.
REQ-021 iss_stall SHALL be 1 when iss_valid and busy is set for iss_rd or any iss_rs entry, after applying this cycle's wb clear (clear visible same cycle).
REQ-022 Accepted issue (iss_valid & !iss_stall & iss_lng) SHALL set busy[iss_rd] next cycle.
REQ-023 wb_we SHALL clear busy[wb_addr] next cycle; simultaneous set and clear of the same bit: set wins.
REQ-024 busy[0] SHALL never set when F0_WRITABLE=0.
REQ-025 fs_dirty SHALL set the cycle after any accepted write; fs_clr clears it; simultaneous write and fs_clr: set wins.

Reset
REQ-026 Reset SHALL immediately zero all 32 registers, busy and fs_dirty, regardless of in-flight issues or writes.
REQ-027 Writebacks arriving after reset for pre-reset issues SHALL still be written (no tagging); flushing them is the pipeline's job.

Configuration
REQ-028 Macro FREG_PRELOAD_EN: when defined, reset SHALL load registers from the package test-constant table (e.g. f1=2.5, f9=+inf, f13=qNaN 0x7FC00000, f14=sNaN 0x7F8C0000, f12=denormal 0x0000FFFF), NaN-boxed when FLEN=64; when undefined, reset SHALL zero all registers.

Structure
REQ-029 Package fp_rf_pkg SHALL hold the canonical qNaN constant, the 32-entry preload table, and the FLEN legality check.
REQ-030 Sub-module fp_scoreboard SHALL own busy, stall and set/clear priority; storage, bypass and boxing stay in the top.

Verification
REQ-031 FLEN=32, reset, write wa f5=0x40200000, read f5 next cycle -> 0x40200000; fs_dirty=1.
REQ-032 Same-cycle wa and wb to f7 (0x1/0x2), read f7 that cycle -> 0x2, stored 0x2.
REQ-033 FLEN=64, single write 0x40400000 to f3 -> stored 0xFFFFFFFF40400000; write double 0x0000000040400000, single read -> 0x7FC00000 low.
REQ-034 Issue lng rd=f10 -> busy[10]=1; issue reading f10 -> iss_stall=1; wb f10 -> stall drops same cycle, busy[10]=0 next.
REQ-035 F0_WRITABLE=0, write f0=0xDEADBEEF -> f0 reads 0; lng issue rd=f0 -> busy[0]=0.
REQ-036 With FREG_PRELOAD_EN, assert reset mid-write -> f1=0x40200000, f14=0x7F8C0000, busy=0, fs_dirty=0.

Source files
------------

// File: rtl/fp_rf_pkg.sv
// Shared constants for the FP register file: canonical qNaN, the reset
// preload table (used when FREG_PRELOAD_EN is defined) and the FLEN check.
package fp_rf_pkg;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;

  // Entry i is the single-precision pattern loaded into f<i> at reset
  localparam logic [31:0] PRELOAD_TABLE [32] = '{
    32'h0000_0000, 32'h4020_0000, 32'h3F80_0000, 32'hBF80_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h8000_0000,
    32'h0000_FFFF, 32'h7FC0_0000, 32'h7F8C_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
  };

  function automatic bit flenLegal(input int flen);
    return (flen == 32) || (flen == 64);
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Pending-write scoreboard: tracks long-latency destinations and stalls
// issue on RAW/WAW hazards, with writeback clears visible the same cycle.
module fp_scoreboard #(
  parameter int NRD         = 3,
  parameter int F0_WRITABLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  input  logic [NRD*5-1:0] iss_rs,
  input  logic             iss_lng,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  output logic             iss_stall,
  output logic [31:0]      busy
);

  logic [31:0] busy_q, busy_d;
  logic [31:0] clearMask, setMask, busyAfterClear;
  logic        hazard, accept;

  // Clear is applied before the hazard check; the set is OR-ed in last so it wins
  always_comb begin
    clearMask = '0;
    if (wb_we) clearMask[wb_addr] = 1'b1;
    busyAfterClear = busy_q & ~clearMask;
    hazard = busyAfterClear[iss_rd];
    for (int i = 0; i < NRD; i++) begin
      hazard = hazard | busyAfterClear[iss_rs[5*i +: 5]];
    end
    iss_stall = iss_valid & hazard;
    accept    = iss_valid & ~hazard & iss_lng;
    setMask   = '0;
    if (accept && ((F0_WRITABLE != 0) || (iss_rd != 5'd0))) setMask[iss_rd] = 1'b1;
    busy_d = busyAfterClear | setMask;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/fp_reg_file_sb.sv
// FP register file with write-first bypass, NaN-boxing and a scoreboard.
// Define FREG_PRELOAD_EN to load fp_rf_pkg::PRELOAD_TABLE at reset.
module fp_reg_file_sb
  import fp_rf_pkg::*;
#(
  parameter int FLEN        = 32,
  parameter int NRD         = 3,
  parameter int F0_WRITABLE = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*5-1:0]    rd_addr,
  input  logic [NRD-1:0]      rd_sgl,
  output logic [NRD*FLEN-1:0] rd_data,
  input  logic                wa_we,
  input  logic [4:0]          wa_addr,
  input  logic [FLEN-1:0]     wa_data,
  input  logic                wa_sgl,
  input  logic                wb_we,
  input  logic [4:0]          wb_addr,
  input  logic [FLEN-1:0]     wb_data,
  input  logic                wb_sgl,
  input  logic                iss_valid,
  input  logic [4:0]          iss_rd,
  input  logic [NRD*5-1:0]    iss_rs,
  input  logic                iss_lng,
  output logic                iss_stall,
  output logic [31:0]         busy,
  output logic                fs_dirty,
  input  logic                fs_clr
);

  if (!flenLegal(FLEN)) begin : g_bad_flen
    $error("fp_reg_file_sb: FLEN must be 32 or 64");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("fp_reg_file_sb: NRD must be 1..4");
  end

  logic [FLEN-1:0] regs_q [32];
  logic            fs_dirty_q, fs_dirty_d;
  logic            waEn, wbEn;
  logic [FLEN-1:0] waBoxed, wbBoxed;

  // A protected f0 swallows the write entirely, so it also never bypasses
  assign waEn = wa_we && ((F0_WRITABLE != 0) || (wa_addr != 5'd0));
  assign wbEn = wb_we && ((F0_WRITABLE != 0) || (wb_addr != 5'd0));

  if (FLEN == 64) begin : g_box64
    assign waBoxed = wa_sgl ? {32'hFFFF_FFFF, wa_data[31:0]} : wa_data;
    assign wbBoxed = wb_sgl ? {32'hFFFF_FFFF, wb_data[31:0]} : wb_data;
  end else begin : g_box32
    logic unusedSgl;
    assign unusedSgl = ^{wa_sgl, wb_sgl, rd_sgl};
    assign waBoxed   = wa_data;
    assign wbBoxed   = wb_data;
  end

`ifdef FREG_PRELOAD_EN
  function automatic logic [FLEN-1:0] preloadValue(input int idx);
    logic [63:0] wide;
    wide = {32'hFFFF_FFFF, PRELOAD_TABLE[idx[4:0]]};
    return wide[FLEN-1:0];
  endfunction
`endif

  // wb is assigned last so it overrides wa when both hit the same register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
`ifdef FREG_PRELOAD_EN
        regs_q[i] <= preloadValue(i);
`else
        regs_q[i] <= '0;
`endif
      end
    end else begin
      if (waEn) regs_q[wa_addr] <= waBoxed;
      if (wbEn) regs_q[wb_addr] <= wbBoxed;
    end
  end

  assign fs_dirty_d = (waEn || wbEn) ? 1'b1 : (fs_clr ? 1'b0 : fs_dirty_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) fs_dirty_q <= 1'b0;
    else       fs_dirty_q <= fs_dirty_d;
  end

  assign fs_dirty = fs_dirty_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [4:0]      addr;
    logic [FLEN-1:0] raw;

    assign addr = rd_addr[5*p +: 5];

    always_comb begin
      raw = regs_q[addr];
      if (waEn && (wa_addr == addr)) raw = waBoxed;
      if (wbEn && (wb_addr == addr)) raw = wbBoxed;
    end

    // A single read of an improperly boxed value yields the canonical qNaN
    if (FLEN == 64) begin : g_unbox
      assign rd_data[FLEN*p +: FLEN] =
        (rd_sgl[p] && (raw[63:32] != 32'hFFFF_FFFF)) ? {32'hFFFF_FFFF, QNAN32} : raw;
    end else begin : g_pass
      assign rd_data[FLEN*p +: FLEN] = raw;
    end
  end

  fp_scoreboard #(
    .NRD         (NRD),
    .F0_WRITABLE (F0_WRITABLE)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rs    (iss_rs),
    .iss_lng   (iss_lng),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .iss_stall (iss_stall),
    .busy      (busy)
  );

endmodule
